// File: rtl/fir8_coef_loader.sv
// fir8_coef_loader: AXI4-Lite master that copies a local coefficient shadow bank
// into the axi_fir8 register map, one single-beat write per coefficient.
// Optional feature macro: FIR8_COEF_LOADER_READBACK_EN
//   defined   -> each coefficient is read back and compared after its write
//   undefined -> write-only; AR/R outputs are tied low
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// VALID and READY are both high. A VALID raised here stays high, with its payload
// unchanged, until that edge, and drops right after it. READY is raised only in the
// state that waits for that response.
module fir8_coef_loader #(
  parameter int          C_NUM_COEF         = 8,
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              coef_wr_en,
  input  logic [$clog2(C_NUM_COEF)-1:0]     coef_wr_idx,
  input  logic [31:0]                       coef_wr_data,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [$clog2(C_NUM_COEF)-1:0]     err_idx,
  output logic [2:0]                        dbg_state,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int IW = $clog2(C_NUM_COEF);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RDATA = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            error_q, error_d;
  logic [IW-1:0]   err_idx_q, err_idx_d;
  logic [31:0]     bank_q [C_NUM_COEF];
  logic [31:0]     bank_d [C_NUM_COEF];
  logic [C_M_AXI_ADDR_WIDTH-1:0] coef_addr;

  // Byte address of coefficient k; wraps at the bus width.
  assign coef_addr = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR + 32'({k_q, 2'b00}));

  // State register plus all sequencer and shadow-bank flops.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      bank_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      bank_q    <= bank_d;
    end
  end

  // Next-state logic: sequencing, per-channel write handshake tracking, bank writes.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    bank_d    = bank_q;
    // Bank is frozen while a sequence runs so the bus payload stays stable.
    if (coef_wr_en && (state_q == S_IDLE)) bank_d[coef_wr_idx] = coef_wr_data;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WR;
          k_d       = '0;
          error_d   = 1'b0;
          err_idx_d = '0;
        end
      end
      S_WR: begin
        // AW and W may complete in different cycles; remember each one.
        aw_done_d = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
        w_done_d  = w_done_q  | (M_AXI_WVALID  & M_AXI_WREADY);
        if (aw_done_d && w_done_d) begin
          state_d   = S_WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            state_d   = S_ERR;
            error_d   = 1'b1;
            err_idx_d = k_q;
          end else begin
`ifdef FIR8_COEF_LOADER_READBACK_EN
            state_d = S_RD;
`else
            state_d = S_NEXT;
`endif
          end
        end
      end
`ifdef FIR8_COEF_LOADER_READBACK_EN
      S_RD: begin
        if (M_AXI_ARREADY) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          if ((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != bank_q[k_q])) begin
            state_d   = S_ERR;
            error_d   = 1'b1;
            err_idx_d = k_q;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
`endif
      S_NEXT: begin
        if (k_q == IW'(C_NUM_COEF - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + IW'(1);
          state_d = S_WR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state and handshake flags.
  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    M_AXI_AWVALID = (state_q == S_WR) && !aw_done_q;
    M_AXI_WVALID  = (state_q == S_WR) && !w_done_q;
    M_AXI_BREADY  = (state_q == S_WRESP);
`ifdef FIR8_COEF_LOADER_READBACK_EN
    M_AXI_ARVALID = (state_q == S_RD);
    M_AXI_ARADDR  = coef_addr;
    M_AXI_RREADY  = (state_q == S_RDATA);
`else
    M_AXI_ARVALID = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_RREADY  = 1'b0;
`endif
  end

`ifndef FIR8_COEF_LOADER_READBACK_EN
  // Read channel inputs have no consumer in the write-only build.
  logic unused_read_inputs;
  assign unused_read_inputs = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

  assign error        = error_q;
  assign err_idx      = err_idx_q;
  assign dbg_state    = state_q;
  assign M_AXI_AWADDR = coef_addr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WDATA  = C_M_AXI_DATA_WIDTH'(bank_q[k_q]);
  assign M_AXI_WSTRB  = '1;

endmodule

// File: tb/tb_fir8_coef_loader.sv
// tb_fir8_coef_loader: table-driven bench for fir8_coef_loader with a reactive
// AXI4-Lite slave model and an expected-write scoreboard queue.
module tb_fir8_coef_loader;

  localparam int          N    = 8;
  localparam int          IW   = 3;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef FIR8_COEF_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic            coef_wr_en;
  logic [IW-1:0]   coef_wr_idx;
  logic [31:0]     coef_wr_data;
  logic            start;
  logic            busy, done, error;
  logic [IW-1:0]   err_idx;
  logic [2:0]      dbg_state;
  logic [31:0]     M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]      M_AXI_WSTRB;
  logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
  logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic            M_AXI_RVALID, M_AXI_RREADY;

  fir8_coef_loader dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .coef_wr_en(coef_wr_en), .coef_wr_idx(coef_wr_idx), .coef_wr_data(coef_wr_data),
    .start(start), .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .dbg_state(dbg_state),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  int          base_done, base_wr, base_rd;
  logic [63:0] exp_q[$];          // {addr, data} of each write the slave must see
  logic [31:0] bm [N];            // bench copy of what was loaded into the bank
  logic [31:0] mem [N];           // slave register file

  // slave configuration
  int aw_delay = 0, w_delay = 0, berr_idx = -1, rcorr_idx = -1;

  // slave internal state
  logic        aw_got, w_got, b_fire, ar_got, r_fire;
  int          aw_wait, w_wait, widx, ridx;
  logic [31:0] cur_addr, cur_data, rd_addr, last_wr_addr;
  logic [3:0]  cur_strb;
  logic [2:0]  cur_prot;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  // ---------------- AXI4-Lite slave model (decides at negedge, transfers at posedge) ----------------
  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    aw_got = 0; w_got = 0; b_fire = 0; ar_got = 0; r_fire = 0; aw_wait = 0; w_wait = 0;
    cur_addr = 0; cur_data = 0; rd_addr = 0; last_wr_addr = 0; cur_strb = 0; cur_prot = 0;
    for (int i = 0; i < N; i++) mem[i] = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        aw_got = 0; w_got = 0; b_fire = 0; ar_got = 0; r_fire = 0; aw_wait = 0; w_wait = 0;
      end else begin
        // B channel: respond once both AW and W have transferred
        if (b_fire) begin
          M_AXI_BVALID = 0; b_fire = 0; aw_got = 0; w_got = 0;
        end else if (M_AXI_BVALID) begin
          if (M_AXI_BREADY) b_fire = 1;
        end else if (aw_got && w_got) begin
          widx = int'((cur_addr - BASE) >> 2);
          wr_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL write_unexpected: actual addr 0x%0h data 0x%0h, required no write", cur_addr, cur_data);
          end else begin
            check("write_addr_data", {cur_addr, cur_data}, exp_q.pop_front());
          end
          check("write_strb_prot", {cur_strb, cur_prot}, {4'hF, 3'b000});
          if (widx >= 0 && widx < N) mem[widx] = cur_data;
          last_wr_addr = cur_addr;
          M_AXI_BRESP  = (widx == berr_idx) ? 2'b10 : 2'b00;
          M_AXI_BVALID = 1;
          if (M_AXI_BREADY) b_fire = 1;
        end
        // AW channel
        if (M_AXI_AWVALID && !aw_got) begin
          if (aw_wait >= aw_delay) begin
            M_AXI_AWREADY = 1; cur_addr = M_AXI_AWADDR; cur_prot = M_AXI_AWPROT;
            aw_got = 1; aw_wait = 0;
          end else begin
            M_AXI_AWREADY = 0; aw_wait++;
          end
        end else begin
          M_AXI_AWREADY = 0;
        end
        // W channel
        if (M_AXI_WVALID && !w_got) begin
          if (w_wait >= w_delay) begin
            M_AXI_WREADY = 1; cur_data = M_AXI_WDATA; cur_strb = M_AXI_WSTRB;
            w_got = 1; w_wait = 0;
          end else begin
            M_AXI_WREADY = 0; w_wait++;
          end
        end else begin
          M_AXI_WREADY = 0;
        end
        // R channel
        if (r_fire) begin
          M_AXI_RVALID = 0; r_fire = 0; ar_got = 0;
        end else if (M_AXI_RVALID) begin
          if (M_AXI_RREADY) r_fire = 1;
        end else if (ar_got) begin
          ridx = int'((rd_addr - BASE) >> 2);
          rd_cnt++;
          check("read_addr", rd_addr, last_wr_addr);
          if (ridx == rcorr_idx)          M_AXI_RDATA = 32'h0000_DEAD;
          else if (ridx >= 0 && ridx < N) M_AXI_RDATA = mem[ridx];
          else                            M_AXI_RDATA = 32'h0;
          M_AXI_RRESP = 2'b00; M_AXI_RVALID = 1;
          if (M_AXI_RREADY) r_fire = 1;
        end
        // AR channel
        if (M_AXI_ARVALID && !ar_got) begin
          M_AXI_ARREADY = 1; rd_addr = M_AXI_ARADDR; ar_got = 1;
        end else begin
          M_AXI_ARREADY = 0;
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin
    forever begin
      @(negedge ACLK);
      if (done) done_cnt++;
      if (done && error) begin
        n_cmp++; n_bad++;
        $display("FAIL done_error_overlap: actual done=1 error=1, required not both");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_coef(input int idx, input logic [31:0] d);
    @(negedge ACLK);
    coef_wr_en = 1; coef_wr_idx = IW'(idx); coef_wr_data = d;
    @(negedge ACLK);
    coef_wr_en = 0;
  endtask

  task automatic push_expected(input int count);
    for (int i = 0; i < count; i++) exp_q.push_back({BASE + 32'(i * 4), bm[i]});
  endtask

  task automatic snapshot();
    base_done = done_cnt; base_wr = wr_cnt; base_rd = rd_cnt;
  endtask

  task automatic do_reset();
    @(negedge ACLK); ARESET = 1;
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    exp_q.delete();
  endtask

  // Start, then check the one-cycle latency to the first write.
  task automatic pulse_start(input string name, input logic [31:0] d0);
    @(negedge ACLK);
    check({name, "_idle_before_start"}, busy, 1'b0);
    start = 1;
    @(negedge ACLK);
    start = 0;
    check({name, "_start_latency"}, {busy, M_AXI_AWVALID, M_AXI_WVALID, error}, 4'b1110);
    check({name, "_first_awaddr"}, M_AXI_AWADDR, BASE);
    check({name, "_first_wdata"}, M_AXI_WDATA, d0);
  endtask

  task automatic wait_end(input string name);
    int  i;
    bit  seen;
    seen = 0;
    for (i = 0; i < 3000 && !seen; i++) begin
      @(negedge ACLK);
      if (done || error) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: actual no done/error after %0d cycles, required one", name, i);
      do_reset();
    end
  endtask

  task automatic post_check(input string name, input logic exp_err, input logic [2:0] exp_eidx,
                            input int exp_wr, input int exp_rd);
    repeat (3) @(negedge ACLK);
    check({name, "_done_pulses"}, 64'(done_cnt - base_done), exp_err ? 64'd0 : 64'd1);
    check({name, "_error"}, error, exp_err);
    if (exp_err) check({name, "_err_idx"}, err_idx, exp_eidx);
    check({name, "_writes"}, 64'(wr_cnt - base_wr), 64'(exp_wr));
    check({name, "_reads"}, 64'(rd_cnt - base_rd), 64'(exp_rd));
    check({name, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle_outputs"},
          {busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 6'b0);
    exp_q.delete();
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    int         aw_d;
    int         w_d;
    int         berr;
    int         rcorr;
    bit         rnd;
    logic       exp_err;
    logic [2:0] exp_eidx;
    int         exp_wr;
    int         exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit found;

    vecs[0] = '{0, 0, -1, -1, 1'b0, 1'b0, 3'd0, 8, RB ? 8 : 0};  // 1..8, zero wait
    vecs[1] = '{3, 0, -1, -1, 1'b1, 1'b0, 3'd0, 8, RB ? 8 : 0};  // AW late, W first
    vecs[2] = '{0, 2, -1, -1, 1'b1, 1'b0, 3'd0, 8, RB ? 8 : 0};  // W late, AW first
    vecs[3] = '{0, 0,  5, -1, 1'b0, 1'b1, 3'd5, 6, RB ? 5 : 0};  // SLVERR on coef 5
    vecs[4] = '{0, 0, -1,  2, 1'b1, RB, RB ? 3'd2 : 3'd0, RB ? 3 : 8, RB ? 3 : 0}; // bad readback
    vecs[5] = '{1, 1,  0, -1, 1'b1, 1'b1, 3'd0, 1, 0};           // SLVERR on first
    vecs[6] = '{2, 1,  7, -1, 1'b1, 1'b1, 3'd7, 8, RB ? 7 : 0};  // SLVERR on last

    ARESET = 1; coef_wr_en = 0; coef_wr_idx = '0; coef_wr_data = '0; start = 0;
    repeat (3) @(negedge ACLK);
    check("reset_outputs",
          {busy, done, error, err_idx, dbg_state, M_AXI_AWVALID, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 14'b0);
    check("reset_wstrb", M_AXI_WSTRB, 4'hF);
    ARESET = 0;
    @(negedge ACLK);

    for (int v = 0; v < 7; v++) begin
      aw_delay = vecs[v].aw_d; w_delay = vecs[v].w_d;
      berr_idx = vecs[v].berr; rcorr_idx = vecs[v].rcorr;
      for (int i = 0; i < N; i++) begin
        bm[i] = vecs[v].rnd ? ($urandom() | 32'h0001_0000) : 32'(i + 1);
        write_coef(i, bm[i]);
      end
      push_expected(vecs[v].exp_wr);
      snapshot();
      pulse_start($sformatf("v%0d", v), bm[0]);
      wait_end($sformatf("v%0d", v));
      post_check($sformatf("v%0d", v), vecs[v].exp_err, vecs[v].exp_eidx,
                 vecs[v].exp_wr, vecs[v].exp_rd);
    end

    // Bank write and start while busy are ignored; start during done is ignored.
    aw_delay = 3; w_delay = 0; berr_idx = -1; rcorr_idx = -1;
    for (int i = 0; i < N; i++) begin
      bm[i] = 32'h0000_00A0 + 32'(i);
      write_coef(i, bm[i]);
    end
    push_expected(N);
    snapshot();
    pulse_start("busy", bm[0]);
    coef_wr_en = 1; coef_wr_idx = '0; coef_wr_data = 32'hBAD0_0BAD; start = 1;
    @(negedge ACLK);
    coef_wr_en = 0; start = 0;
    wait_end("busy");
    start = 1;
    @(negedge ACLK);
    start = 0;
    post_check("busy", 1'b0, 3'd0, 8, RB ? 8 : 0);
    aw_delay = 0;
    push_expected(N);
    snapshot();
    pulse_start("bank_kept", bm[0]);
    wait_end("bank_kept");
    post_check("bank_kept", 1'b0, 3'd0, 8, RB ? 8 : 0);

    // Reset in the WR state of coefficient 3.
    for (int i = 0; i < N; i++) begin
      bm[i] = 32'hC0DE_0000 + 32'(i);
      write_coef(i, bm[i]);
    end
    push_expected(N);
    snapshot();
    pulse_start("midreset", bm[0]);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge ACLK);
      if (M_AXI_AWVALID && (M_AXI_AWADDR == BASE + 32'd12)) found = 1;
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL midreset_find_coef3: actual not seen, required AWVALID at 0x%0h", BASE + 32'd12);
    end
    #2 ARESET = 1;
    #1;
    check("midreset_outputs",
          {busy, done, error, err_idx, dbg_state, M_AXI_AWVALID, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 14'b0);
    check("midreset_pending_writes", 64'(exp_q.size()), 64'd5);
    exp_q.delete();
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    check("midreset_no_done", 64'(done_cnt - base_done), 64'd0);

    // Bank now all zero; write idx 0 in the same cycle as start.
    for (int i = 0; i < N; i++) bm[i] = 32'h0;
    bm[0] = 32'h1234_5678;
    push_expected(N);
    snapshot();
    @(negedge ACLK);
    coef_wr_en = 1; coef_wr_idx = '0; coef_wr_data = bm[0]; start = 1;
    @(negedge ACLK);
    coef_wr_en = 0; start = 0;
    check("zero_load_start_latency", {busy, M_AXI_AWVALID, M_AXI_WVALID}, 3'b111);
    check("zero_load_first_wdata", M_AXI_WDATA, bm[0]);
    wait_end("zero_load");
    post_check("zero_load", 1'b0, 3'd0, 8, RB ? 8 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
